// File: rtl/replica_pkg.sv
// Shared types for the replica chain: city geometry, beat payload and exchange commands.
package replica_pkg;

  localparam int city_num     = 32;
  localparam int city_div     = city_num / 8;
  localparam int city_num_log = $clog2(city_num);
  localparam int beat_w       = (city_div > 1) ? $clog2(city_div) : 1;

  typedef logic [7:0][city_num_log-1:0] replica_data_t;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PREV = 2'd1,
    FOLW = 2'd2,
    SELF = 2'd3
  } exchange_command_t;

  typedef exchange_command_t [1:0] exch_pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } shift_state_t;

  function automatic exch_pair_t exch_pair(exchange_command_t cmd);
    exch_pair_t p;
    p[0] = cmd;
    p[1] = cmd;
    return p;
  endfunction

endpackage

// File: rtl/replica_tour_check.sv
// Per-replica tour sanity check: flags a repeated or out-of-range city index.
// Only instantiated when REPLICA_SHIFT_IN_CHECK_EN is defined.
module replica_tour_check
  import replica_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clr_seen,
  input  logic                    i_clr_err,
  input  logic                    i_valid,
  input  logic [city_num_log-1:0] i_city,
  output logic                    o_err
);

  logic [city_num-1:0] r_seen;
  logic                r_err;
  logic                w_in_range;
  logic                w_bad;

  assign w_in_range = 32'(i_city) < city_num;
  assign w_bad      = i_valid && (!w_in_range || r_seen[i_city]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seen <= '0;
      r_err  <= 1'b0;
    end else begin
      if (i_clr_seen)
        r_seen <= '0;
      else if (i_valid && w_in_range)
        r_seen[i_city] <= 1'b1;

      // err is sticky across replicas; only a fresh load clears it
      if (i_clr_err)
        r_err <= 1'b0;
      else if (w_bad)
        r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/replica_shift_in.sv
// Collects host cities into a beat buffer and streams REPLICA_NUM tours into the replica chain.
// Optional tour checking is enabled with the REPLICA_SHIFT_IN_CHECK_EN macro.
module replica_shift_in
  import replica_pkg::*;
#(
  parameter int REPLICA_NUM = 4
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    s_valid,
  input  logic [city_num_log-1:0] s_data,
  output logic                    s_ready,
  output logic                    out_valid,
  output replica_data_t           out_data,
  output exchange_command_t [1:0] out_exchange,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int REP_W = (REPLICA_NUM > 1) ? $clog2(REPLICA_NUM) : 1;
  localparam logic [REP_W-1:0]  LAST_REP  = REP_W'(REPLICA_NUM - 1);
  localparam logic [beat_w-1:0] LAST_BEAT = beat_w'(city_div - 1);

  shift_state_t      r_state;
  logic [REP_W-1:0]  r_rep;
  logic [beat_w-1:0] r_beat;
  logic [2:0]        r_lane;
  replica_data_t     r_buf [city_div];
  logic              r_s_ready;
  logic              r_out_valid;
  replica_data_t     r_out_data;
  exch_pair_t        r_out_exch;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_last_city;
  logic [beat_w-1:0] w_beat_nx;
  replica_data_t     w_first_beat;

  function automatic replica_data_t merge_lane(replica_data_t word, logic [2:0] lane,
                                               logic [city_num_log-1:0] city);
    replica_data_t w;
    w       = word;
    w[lane] = city;
    return w;
  endfunction

  assign w_accept    = r_s_ready && s_valid;
  assign w_last_city = w_accept && (r_beat == LAST_BEAT) && (r_lane == 3'd7);
  assign w_beat_nx   = r_beat + 1'b1;
  // With a single-beat tour the first emitted beat is still being written this cycle
  assign w_first_beat = (city_div == 1) ? merge_lane(r_buf[0], r_lane, s_data) : r_buf[0];

  always_ff @(posedge clk) begin
    if (w_accept)
      r_buf[r_beat][r_lane] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rep       <= '0;
      r_beat      <= '0;
      r_lane      <= '0;
      r_s_ready   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_exch  <= exch_pair(NOP);
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE && abort) begin
        r_state     <= IDLE;
        r_s_ready   <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_exch  <= exch_pair(NOP);
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state   <= FILL;
              r_rep     <= '0;
              r_beat    <= '0;
              r_lane    <= '0;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
          FILL: begin
            if (w_last_city) begin
              r_state     <= EMIT;
              r_beat      <= '0;
              r_lane      <= '0;
              r_s_ready   <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_first_beat;
              r_out_exch  <= exch_pair(PREV);
            end else if (w_accept) begin
              r_lane <= r_lane + 3'd1;
              if (r_lane == 3'd7)
                r_beat <= w_beat_nx;
            end
          end
          EMIT: begin
            r_out_exch <= exch_pair(NOP);
            if (r_beat == LAST_BEAT) begin
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_beat      <= '0;
              if (r_rep == LAST_REP) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_rep     <= r_rep + 1'b1;
                r_state   <= FILL;
                r_s_ready <= 1'b1;
              end
            end else begin
              r_beat     <= w_beat_nx;
              r_out_data <= r_buf[w_beat_nx];
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_ready      = r_s_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_exchange = r_out_exch;
  assign busy         = r_busy;
  assign done         = r_done;

`ifdef REPLICA_SHIFT_IN_CHECK_EN
  logic w_start_go;
  logic w_clr_seen;

  assign w_start_go = (r_state == IDLE) && start;
  assign w_clr_seen = w_start_go || ((r_state == EMIT) && (r_beat == LAST_BEAT));

  replica_tour_check u_tour_check (
    .clk        (clk),
    .reset      (reset),
    .i_clr_seen (w_clr_seen),
    .i_clr_err  (w_start_go),
    .i_valid    (w_accept),
    .i_city     (s_data),
    .o_err      (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_replica_shift_in.sv
// Directed bench for replica_shift_in: full loads, hold-off, abort, ignored start, tour error, reset.
`timescale 1ns/1ps
module tb_replica_shift_in;
  import replica_pkg::*;

  localparam int RN  = 4;
  localparam int CPR = city_num;
  localparam logic [3:0] EXCH_PREV = 4'b0101;
  localparam logic [3:0] EXCH_NOP  = 4'b0000;
`ifdef REPLICA_SHIFT_IN_CHECK_EN
  localparam logic EXP_DUP_ERR = 1'b1;
`else
  localparam logic EXP_DUP_ERR = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset, start, abort, s_valid;
  logic [city_num_log-1:0] s_data;
  logic                    s_ready, out_valid, busy, done, err;
  replica_data_t           out_data;
  exchange_command_t [1:0] out_exchange;

  replica_shift_in #(.REPLICA_NUM(RN)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_exchange (out_exchange),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cities sent per replica; the expected beats are rebuilt from this table
  int tbl [RN][CPR];

  function automatic void fill_tbl();
    for (int r = 0; r < RN; r++)
      for (int c = 0; c < CPR; c++)
        tbl[r][c] = c;
  endfunction

  function automatic replica_data_t exp_word(int k);
    replica_data_t w;
    int r = k / city_div;
    int b = k % city_div;
    for (int l = 0; l < 8; l++)
      w[l] = city_num_log'(tbl[r][8*b + l]);
    return w;
  endfunction

  int            cyc = 0;
  replica_data_t q_data [$];
  logic [3:0]    q_exch [$];
  int            q_cyc  [$];
  int            last_beat_cyc = 0;
  int            done_cyc = 0;
  int            n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      q_data.push_back(out_data);
      q_exch.push_back(out_exchange);
      q_cyc.push_back(cyc);
      last_beat_cyc = cyc;
      chk("s_ready_in_emit", s_ready, 1'b0);
    end else begin
      chk("data_zero_idle", out_data, '0);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_exch.delete();
    q_cyc.delete();
    n_done = 0;
  endtask

  task automatic stream(input int n, input bit toggle, input int start_at, output bit ok);
    int idx = 0;
    int guard = 0;
    ok = 1'b1;
    while (idx < n) begin
      @(negedge clk);
      s_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = city_num_log'(tbl[idx / CPR][idx % CPR]);
      start   = (idx == start_at);
      if (s_valid && s_ready) idx++;
      guard++;
      if (guard > 5000) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic run_full(input string tag, input bit toggle, input int start_at, input logic exp_err);
    bit ok;
    int g;
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_err_clr"}, err, 1'b0);
    stream(RN*CPR, toggle, start_at, ok);
    chk({tag, "_stream_to"}, ok, 1'b1);
    g = 0;
    while (n_done == 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_done_seen"}, n_done, 1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_done_lat"}, done_cyc - last_beat_cyc, 1);
    chk({tag, "_nbeats"}, q_data.size(), RN*city_div);
    for (int k = 0; k < q_data.size() && k < RN*city_div; k++) begin
      chk($sformatf("%s_beat%0d", tag, k), q_data[k], exp_word(k));
      chk($sformatf("%s_exch%0d", tag, k), q_exch[k], (k % city_div == 0) ? EXCH_PREV : EXCH_NOP);
      if (k % city_div != 0)
        chk($sformatf("%s_gap%0d", tag, k), q_cyc[k] - q_cyc[k-1], 1);
    end
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    fill_tbl();
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_exch", out_exchange, EXCH_NOP);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_full("base", 1'b0, -1, 1'b0);
    run_full("tog", 1'b1, -1, 1'b0);
    run_full("bsy", 1'b0, 40, 1'b0);

    // abort while replica 2 beat 1 is on the output
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    stream(3*CPR, 1'b0, -1, ok);
    chk("abt_stream_to", ok, 1'b1);
    @(negedge clk);
    chk("abt_beat1_valid", out_valid, 1'b1);
    chk("abt_beat1_data", out_data, exp_word(9));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_valid_drop", out_valid, 1'b0);
    chk("abt_busy_drop", busy, 1'b0);
    chk("abt_s_ready", s_ready, 1'b0);
    repeat (5) @(negedge clk);
    chk("abt_no_done", n_done, 0);
    chk("abt_nbeats", q_data.size(), 10);
    run_full("post_abt", 1'b0, -1, 1'b0);

    // abort in IDLE does nothing; start beats abort in the same IDLE cycle
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_wins_busy", busy, 1'b1);
    chk("start_wins_ready", s_ready, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("fill_abort_busy", busy, 1'b0);

    // replica 1 repeats city 5 in place of city 6
    tbl[1][6] = 5;
    run_full("dup", 1'b0, -1, EXP_DUP_ERR);
    repeat (5) @(negedge clk);
    chk("dup_err_held", err, EXP_DUP_ERR);
    fill_tbl();
    run_full("clr", 1'b0, -1, 1'b0);

    // reset in the middle of a fill
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    stream(20, 1'b0, -1, ok);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_s_ready", s_ready, 1'b0);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_exch", out_exchange, EXCH_NOP);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_err", err, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrst_no_beats", q_data.size(), 0);
    chk("mrst_busy_after", busy, 1'b0);
    run_full("post_rst", 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
